// File: rtl/lif_scheduler_pkg.sv
// Shared types and default parameters for the LIF timestep scheduler.
package lif_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_EMIT,
        S_DONE
    } lif_state_e;

    localparam int DEF_N_NEURONS  = 8;
    localparam int DEF_THRESH_RST = 200;
    localparam int DEF_BETA_SHIFT = 1;

endpackage

// File: rtl/lif_scheduler_if.sv
// Config, control, spike-stream and debug-read signals of the scheduler.
interface lif_scheduler_if #(
    parameter int AW = 3
);
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [7:0]    cur_data;
    logic          thr_we;
    logic [7:0]    thr_data;
    logic          step_start;
    logic          busy;
    logic          step_done;
    logic          spike_valid;
    logic [AW-1:0] spike_id;
    logic          spike_ready;
    logic          cfg_err;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_state;

    modport slave (
        input  cur_we, cur_addr, cur_data,
        input  thr_we, thr_data, step_start,
        input  spike_ready, rd_addr,
        output busy, step_done, spike_valid,
        output spike_id, cfg_err, rd_state
    );

    modport master (
        output cur_we, cur_addr, cur_data,
        output thr_we, thr_data, step_start,
        output spike_ready, rd_addr,
        input  busy, step_done, spike_valid,
        input  spike_id, cfg_err, rd_state
    );
endinterface

// File: rtl/lif_scheduler_update_unit.sv
// Leaky integrate-and-fire arithmetic for one neuron; shared across all.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int BETA_SHIFT = DEF_BETA_SHIFT
) (
    input  logic [7:0] state_i,
    input  logic [7:0] current_i,
    input  logic [7:0] threshold_i,
    output logic [7:0] next_state_o,
    output logic       spike_o
);
    logic [7:0] leak;

    assign spike_o = (state_i >= threshold_i);
    // A firing neuron drops its history; the sum wraps modulo 256.
    assign leak = spike_o ? 8'd0 : (state_i >> BETA_SHIFT);
    assign next_state_o = current_i + leak;
endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF neuron array: one update per cycle, then spike drain.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int THRESH_RST = DEF_THRESH_RST,
    parameter int BETA_SHIFT = DEF_BETA_SHIFT
) (
    input logic      clk,
    input logic      rst,
    lif_scheduler_if.slave bus
);
    localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

    logic [7:0]           mem_q [N_NEURONS];
    logic [7:0]           cur_q [N_NEURONS];
    logic [7:0]           thr_q;
    logic [N_NEURONS-1:0] pend_q, pend_d;
    lif_state_e           fsm_q, fsm_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW-1:0]        first_id;
    logic [7:0]           nxt;
    logic                 spk;

    lif_update_unit #(
        .BETA_SHIFT(BETA_SHIFT)
    ) u_upd (
        .state_i     (mem_q[idx_q]),
        .current_i   (cur_q[idx_q]),
        .threshold_i (thr_q),
        .next_state_o(nxt),
        .spike_o     (spk)
    );

    // Descending scan so the lowest set bit wins.
    always_comb begin
        first_id = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pend_q[i]) first_id = AW'(i);
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        idx_d  = idx_q;
        pend_d = pend_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (bus.step_start) begin
                    fsm_d = S_UPDATE;
                    idx_d = '0;
                end
            end
            S_UPDATE: begin
                if (spk) pend_d[idx_q] = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d = '0;
                    fsm_d = (|pend_d) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (bus.spike_ready) begin
                    pend_d[first_id] = 1'b0;
                    if (pend_d == '0) fsm_d = S_DONE;
                end
            end
            S_DONE: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= S_IDLE;
            idx_q  <= '0;
            pend_q <= '0;
            thr_q  <= 8'(THRESH_RST);
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            fsm_q  <= fsm_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            if (fsm_q == S_IDLE) begin
                if (bus.cur_we) cur_q[bus.cur_addr] <= bus.cur_data;
                if (bus.thr_we) thr_q <= bus.thr_data;
            end
            if (fsm_q == S_UPDATE) mem_q[idx_q] <= nxt;
        end
    end

    assign bus.busy        = (fsm_q != S_IDLE);
    assign bus.step_done   = (fsm_q == S_DONE);
    assign bus.spike_valid = (fsm_q == S_EMIT);
    assign bus.spike_id    = first_id;
    assign bus.cfg_err     = (bus.cur_we | bus.thr_we) & bus.busy;
    assign bus.rd_state    = mem_q[bus.rd_addr];
endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: reset, leak, spikes, stalls, wrap, errors.
module tb_lif_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lif_scheduler_if #(.AW(3)) bus ();

    lif_scheduler dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int busy_cnt;
    int spikes[$];

    always @(posedge clk) if (bus.step_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cur_we = 1'b0;
        bus.cur_addr = '0;
        bus.cur_data = '0;
        bus.thr_we = 1'b0;
        bus.thr_data = '0;
        bus.step_start = 1'b0;
        bus.spike_ready = 1'b1;
        bus.rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wr_cur(input int a, input int d);
        bus.cur_we = 1'b1;
        bus.cur_addr = 3'(a);
        bus.cur_data = 8'(d);
        tick();
        bus.cur_we = 1'b0;
    endtask

    task automatic wr_thr(input int d);
        bus.thr_we = 1'b1;
        bus.thr_data = 8'(d);
        tick();
        bus.thr_we = 1'b0;
    endtask

    task automatic rd(input int a, output int v);
        bus.rd_addr = 3'(a);
        #1;
        v = int'(bus.rd_state);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.step_done !== 1'b1 && n < 200) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.spike_valid === 1'b1 && bus.spike_ready === 1'b1)
                spikes.push_back(int'(bus.spike_id));
            tick();
            n++;
        end
        if (n >= 200) chk({tag, "_timeout"}, 32'd0, 32'd1);
        if (bus.busy === 1'b1) busy_cnt++;
        tick();
    endtask

    task automatic do_step();
        spikes.delete();
        busy_cnt = 0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        wait_done("step");
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.spike_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({tag, "_novalid"}, 32'd0, 32'd1);
    endtask

    initial begin
        int v;
        int d0;
        int exp_q[5];

        // Reset values while rst is held high
        rst = 1'b1;
        bus.cur_we = 1'b0;
        bus.cur_addr = '0;
        bus.cur_data = '0;
        bus.thr_we = 1'b1;
        bus.thr_data = 8'd9;
        bus.step_start = 1'b1;
        bus.spike_ready = 1'b1;
        bus.rd_addr = 3'd5;
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.step_done), 32'd0);
        chk("rst_valid", 32'(bus.spike_valid), 32'd0);
        chk("rst_cfgerr", 32'(bus.cfg_err), 32'd0);
        chk("rst_id", 32'(bus.spike_id), 32'd0);
        chk("rst_state5", 32'(bus.rd_state), 32'd0);
        do_reset();

        // Leak sequence on neuron 0
        wr_thr(200);
        wr_cur(0, 100);
        exp_q = '{100, 150, 175, 187, 193};
        for (int k = 0; k < 5; k++) begin
            do_step();
            rd(0, v);
            chk($sformatf("leak_s%0d", k), 32'(v), 32'(exp_q[k]));
            chk($sformatf("leak_nspk%0d", k), 32'(spikes.size()), 32'd0);
        end

        // Single spike with leak suppression and busy length
        do_reset();
        wr_cur(3, 250);
        do_step();
        rd(3, v);
        chk("n3_first", 32'(v), 32'd250);
        chk("n3_nspk1", 32'(spikes.size()), 32'd0);
        chk("n3_busy1", 32'(busy_cnt), 32'd9);
        do_step();
        rd(3, v);
        chk("n3_second", 32'(v), 32'd250);
        chk("n3_nspk2", 32'(spikes.size()), 32'd1);
        if (spikes.size() > 0) chk("n3_id", 32'(spikes[0]), 32'd3);
        chk("n3_busy2", 32'(busy_cnt), 32'd10);
        chk("n3_idle", 32'(bus.busy), 32'd0);

        // Three spikes drained under back-pressure
        do_reset();
        wr_cur(1, 210);
        wr_cur(4, 210);
        wr_cur(6, 210);
        do_step();
        bus.spike_ready = 1'b0;
        d0 = done_cnt;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        wait_valid("stall");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_v%0d", k), 32'(bus.spike_valid), 32'd1);
            chk($sformatf("stall_id%0d", k), 32'(bus.spike_id), 32'd1);
            tick();
        end
        bus.spike_ready = 1'b1;
        spikes.delete();
        for (int k = 0; k < 20 && bus.spike_valid === 1'b1; k++) begin
            spikes.push_back(int'(bus.spike_id));
            tick();
        end
        chk("drain_done", 32'(bus.step_done), 32'd1);
        chk("drain_n", 32'(spikes.size()), 32'd3);
        if (spikes.size() == 3) begin
            chk("drain_id0", 32'(spikes[0]), 32'd1);
            chk("drain_id1", 32'(spikes[1]), 32'd4);
            chk("drain_id2", 32'(spikes[2]), 32'd6);
        end
        tick();
        chk("drain_ndone", 32'(done_cnt - d0), 32'd1);

        // Modulo-256 wrap
        do_reset();
        wr_thr(255);
        wr_cur(0, 254);
        do_step();
        rd(0, v);
        chk("wrap_pre", 32'(v), 32'd254);
        wr_cur(0, 200);
        do_step();
        rd(0, v);
        chk("wrap_71", 32'(v), 32'd71);

        // Write dropped while busy
        do_reset();
        wr_cur(2, 10);
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        bus.cur_we = 1'b1;
        bus.cur_addr = 3'd2;
        bus.cur_data = 8'd99;
        #1;
        chk("cfgerr_hi", 32'(bus.cfg_err), 32'd1);
        tick();
        bus.cur_we = 1'b0;
        #1;
        chk("cfgerr_lo", 32'(bus.cfg_err), 32'd0);
        busy_cnt = 0;
        wait_done("drop");
        rd(2, v);
        chk("drop_s1", 32'(v), 32'd10);
        do_step();
        rd(2, v);
        chk("drop_s2", 32'(v), 32'd15);

        // step_start ignored during EMIT
        do_reset();
        wr_cur(5, 210);
        do_step();
        bus.spike_ready = 1'b0;
        d0 = done_cnt;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        wait_valid("emit_start");
        bus.step_start = 1'b1;
        #1;
        chk("emit_start_err", 32'(bus.cfg_err), 32'd0);
        tick();
        bus.step_start = 1'b0;
        bus.spike_ready = 1'b1;
        busy_cnt = 0;
        wait_done("emit_start");
        tick();
        tick();
        chk("emit_start_ndone", 32'(done_cnt - d0), 32'd1);
        chk("emit_start_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of EMIT
        do_reset();
        wr_thr(50);
        wr_cur(0, 100);
        do_step();
        bus.spike_ready = 1'b0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        wait_valid("mid_rst");
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.spike_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        rd(0, v);
        chk("midrst_state0", 32'(v), 32'd0);
        tick();
        rst = 1'b0;
        bus.spike_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
        wr_cur(0, 150);
        do_step();
        do_step();
        rd(0, v);
        chk("midrst_thr", 32'(v), 32'd225);
        chk("midrst_nspk", 32'(spikes.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): N_NEURONS, 8, number of time-multiplexed neurons; THRESH_RST, 200, threshold value after reset; BETA_SHIFT, 1, leak right-shift amount.
REQ-002 clk  in  1  the only clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cur_we  in  1  write strobe for a per-neuron input-current register.
REQ-005 cur_addr  in  $clog2(N_NEURONS)  neuron index for cur_we.
REQ-006 cur_data  in  8  input-current value for cur_we.
REQ-007 thr_we  in  1  write strobe for the threshold register; thr_data  in  8  new threshold.
REQ-008 step_start  in  1  single-cycle request to run one timestep over all neurons.
REQ-009 busy  out  1  high from the cycle after an accepted step_start until step_done.
REQ-010 step_done  out  1  single-cycle pulse marking the end of a timestep.
REQ-011 spike_valid  out  1, spike_id  out  $clog2(N_NEURONS), spike_ready  in  1  spike-event valid/ready stream.
REQ-012 cfg_err  out  1  single-cycle pulse when a cur_we or thr_we is dropped.
REQ-013 rd_addr  in  $clog2(N_NEURONS), rd_state  out  8  combinational read of the membrane state of neuron rd_addr.

Function
REQ-014 The block SHALL hold an 8-bit membrane state and an 8-bit current register per neuron, one shared threshold register, and one N_NEURONS-bit pending-spike vector.
REQ-015 The FSM SHALL have states IDLE, UPDATE, EMIT and DONE.
REQ-016 In IDLE, step_start SHALL be accepted and move the FSM to UPDATE with index 0; step_start in any other state SHALL be ignored without an error flag.
REQ-017 UPDATE SHALL process one neuron per cycle in ascending index order, taking exactly N_NEURONS cycles.
REQ-018 Per neuron: spike = (state >= threshold), evaluated on the pre-update state; next = current + (spike ? 0 : state >> BETA_SHIFT), truncated to 8 bits (modulo-256 wrap, no saturation).
REQ-019 UPDATE SHALL set pending bit i when neuron i spikes.
REQ-020 After the last neuron, the FSM SHALL go to EMIT if any pending bit is set, else to DONE.
REQ-021 EMIT SHALL present the lowest-index pending bit as spike_id with spike_valid high; spike_id SHALL hold stable until spike_ready.
REQ-022 On a cycle with spike_valid and spike_ready both high, the block SHALL clear that bit and present the next pending bit in the next cycle; when the last bit is cleared, the FSM SHALL go to DONE.
REQ-023 spike_valid SHALL be low outside EMIT.
REQ-024 DONE SHALL last one cycle, assert step_done, and return the FSM to IDLE.
REQ-025 cur_we and thr_we SHALL take effect only in IDLE; while busy they SHALL be dropped, and cfg_err SHALL pulse in the same cycle.
REQ-026 If step_start and a write occur together in IDLE, the write SHALL commit and the new timestep SHALL use the written value.
REQ-027 Current registers SHALL persist across timesteps; they SHALL NOT be auto-cleared.

Reset
REQ-028 While rst is high, all states, currents and pending bits SHALL be 0, the threshold SHALL be THRESH_RST, and the FSM SHALL be IDLE.
REQ-029 While rst is high, busy, step_done, spike_valid and cfg_err SHALL be 0, and spike_id SHALL be 0.
REQ-030 Reset asserted mid-UPDATE or mid-EMIT SHALL abandon the timestep without emitting step_done.

Structure
REQ-031 Package lif_pkg SHALL hold the FSM state enum, N_NEURONS, THRESH_RST and BETA_SHIFT defaults.
REQ-032 The per-neuron arithmetic SHALL be one combinational sub-module lif_update_unit (inputs: state, current, threshold; outputs: next_state, spike), instantiated once and shared.

Verification
REQ-033 Reset, then thr=200, current[0]=100, all other currents 0, five steps with spike_ready=1 -> neuron 0 states 100, 150, 175, 187, 193; no spikes.
REQ-034 current[3]=250, one step -> state[3]=250, no spike; second step -> spike_id=3 emitted once and state[3]=250 (leak suppressed); busy spans the full step.
REQ-035 Neurons 1, 4 and 6 above threshold, spike_ready held low 5 cycles, then high -> spike_id sequence 1, 4, 6 with spike_id stable while stalled, then step_done one cycle after the last handshake.
REQ-036 state=254, current=200, threshold=255 -> next state (200+127) mod 256 = 71 (wrap, not saturate).
REQ-037 cur_we during UPDATE -> cfg_err pulse and the register is unchanged; step_start during EMIT -> ignored, exactly one step_done.
REQ-038 rst pulsed mid-EMIT -> spike_valid low immediately, all states 0, threshold 200, no step_done.
